audio_bus_responder: RTL and testbench

- Target-side responder for the Nios external bus bridge. It decodes bridge cycles (address, bus_enable, byte_enable, rw, write_data) and returns read_data, acknowledge and irq.
- It contains a control/status register pair, a TX sample FIFO that feeds the codec serializer, and an RX sample FIFO that is filled from the codec deserializer.
- It sits between the bridge conduit of the Nios system and the audio codec datapath.

---
 rtl/audio_bus_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/audio_bus_responder.sv | 178 +++++++++++++++++
 tb/tb_audio_bus_responder.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_bus_pkg.sv
// rtl/audio_bus_pkg.sv - register map, bit positions and bus FSM states for the audio bus responder
package audio_bus_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_TX_DATA = 2'd2;
    localparam logic [1:0] REG_RX_DATA = 2'd3;

    localparam int CTRL_WIDTH     = 4;
    localparam int CTRL_TX_EN     = 0;
    localparam int CTRL_RX_EN     = 1;
    localparam int CTRL_TX_IRQ_EN = 2;
    localparam int CTRL_RX_IRQ_EN = 3;

    localparam int STAT_TX_LEVEL_LSB = 0;
    localparam int STAT_RX_LEVEL_LSB = 8;
    localparam int STAT_TX_FULL      = 16;
    localparam int STAT_RX_EMPTY     = 17;
    localparam int STAT_RX_OVERFLOW  = 18;
    localparam int STAT_TX_DROP      = 19;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ACK,
        ST_RELEASE
    } bus_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; pushes when full and pops when empty are ignored
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Full is checked against the current count, so a simultaneous pop never admits a push.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == DEPTH_LVL);
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/audio_bus_responder.sv
// rtl/audio_bus_responder.sv - bridge-side register target with TX/RX sample FIFOs for the audio codec
module audio_bus_responder
    import audio_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TX_LOW_WM  = 4,
    parameter int RX_HIGH_WM = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] address,
    input  logic        bus_enable,
    input  logic [3:0]  byte_enable,
    input  logic        rw,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        acknowledge,
    output logic        irq,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    input  logic [15:0] sample_in,
    input  logic        sample_in_valid
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] TX_LOW_WM_LVL  = LW'(TX_LOW_WM);
    localparam logic [LW-1:0] RX_HIGH_WM_LVL = LW'(RX_HIGH_WM);

    bus_state_t state;
    bus_state_t next_state;
    logic       access;
    logic       wait_low;

    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  rx_overflow;
    logic                  tx_drop;

    logic [LW-1:0] tx_level;
    logic [LW-1:0] rx_level;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_full;
    logic          rx_empty;
    logic [15:0]   tx_head;
    logic [15:0]   rx_head;

    logic [1:0]  reg_sel;
    logic        bus_write;
    logic        bus_read;
    logic        tx_push_req;
    logic        tx_pop;
    logic        rx_push;
    logic        rx_pop;
    logic        tx_drop_evt;
    logic        rx_ovf_evt;
    logic        status_clr;
    logic        ctrl_we;
    logic [31:0] status_word;
    logic [31:0] read_mux;
    logic        unused_bits;

    assign reg_sel     = address[3:2];
    assign unused_bits = &{1'b0, address[10:4], address[1:0], byte_enable[3],
                           write_data[31:20], write_data[17:16]};

    // wait_low blocks a request that was already held across reset until the bridge drops it.
    always_comb begin
        next_state = state;
        access     = 1'b0;
        case (state)
            ST_IDLE:    if (bus_enable && !wait_low) next_state = ST_ACCESS;
            ST_ACCESS: begin
                access     = 1'b1;
                next_state = ST_ACK;
            end
            ST_ACK:     next_state = ST_RELEASE;
            ST_RELEASE: if (!bus_enable) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    assign bus_write   = access & ~rw;
    assign bus_read    = access & rw;
    assign tx_push_req = bus_write && (reg_sel == REG_TX_DATA) && (byte_enable[1:0] == 2'b11);
    assign ctrl_we     = bus_write && (reg_sel == REG_CTRL) && byte_enable[0];
    assign status_clr  = bus_write && (reg_sel == REG_STATUS) && byte_enable[2];
    assign rx_pop      = bus_read && (reg_sel == REG_RX_DATA);

    assign sample_valid = ctrl[CTRL_TX_EN] & ~tx_empty;
    assign sample_out   = tx_head;
    assign tx_pop       = sample_valid & sample_ready;
    assign rx_push      = sample_in_valid & ctrl[CTRL_RX_EN];
    assign tx_drop_evt  = tx_push_req & tx_full;
    assign rx_ovf_evt   = rx_push & rx_full;

    sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push_req),
        .push_data (write_data[15:0]),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (sample_in),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    always_comb begin
        status_word = '0;
        status_word[STAT_TX_LEVEL_LSB +: 8] = 8'(tx_level);
        status_word[STAT_RX_LEVEL_LSB +: 8] = 8'(rx_level);
        status_word[STAT_TX_FULL]           = tx_full;
        status_word[STAT_RX_EMPTY]          = rx_empty;
        status_word[STAT_RX_OVERFLOW]       = rx_overflow;
        status_word[STAT_TX_DROP]           = tx_drop;
    end

    always_comb begin
        read_mux = '0;
        case (reg_sel)
            REG_CTRL:    read_mux[CTRL_WIDTH-1:0] = ctrl;
            REG_STATUS:  read_mux = status_word;
            REG_TX_DATA: read_mux = '0;
            REG_RX_DATA: if (!rx_empty) read_mux[15:0] = rx_head;
            default:     read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_low    <= 1'b1;
            acknowledge <= 1'b0;
            read_data   <= '0;
        end else begin
            state       <= next_state;
            acknowledge <= access;
            if (!bus_enable) wait_low <= 1'b0;
            if (access) read_data <= rw ? read_mux : 32'h0;
        end
    end

    // A new event in the same cycle as a W1C clear leaves the sticky bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl        <= '0;
            rx_overflow <= 1'b0;
            tx_drop     <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (ctrl_we) ctrl <= write_data[CTRL_WIDTH-1:0];
            if (rx_ovf_evt)
                rx_overflow <= 1'b1;
            else if (status_clr && write_data[STAT_RX_OVERFLOW])
                rx_overflow <= 1'b0;
            if (tx_drop_evt)
                tx_drop <= 1'b1;
            else if (status_clr && write_data[STAT_TX_DROP])
                tx_drop <= 1'b0;
            irq <= (ctrl[CTRL_TX_IRQ_EN] && (tx_level <= TX_LOW_WM_LVL)) ||
                   (ctrl[CTRL_RX_IRQ_EN] && (rx_level >= RX_HIGH_WM_LVL));
        end
    end

endmodule

// File: tb/tb_audio_bus_responder.sv
// tb/tb_audio_bus_responder.sv - directed and randomized checks against a queue-based model
module tb_audio_bus_responder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] address = '0;
    logic        bus_enable = 1'b0;
    logic [3:0]  byte_enable = '0;
    logic        rw = 1'b0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        acknowledge;
    logic        irq;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_in_valid = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    logic [3:0]  m_ctrl;
    bit          m_ovf;
    bit          m_drop;

    audio_bus_responder dut (
        .clk             (clk),
        .reset           (reset),
        .address         (address),
        .bus_enable      (bus_enable),
        .byte_enable     (byte_enable),
        .rw              (rw),
        .write_data      (write_data),
        .read_data       (read_data),
        .acknowledge     (acknowledge),
        .irq             (irq),
        .sample_out      (sample_out),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_status();
        return {12'h0, m_drop, m_ovf, (rxq.size() == 0), (txq.size() == DEPTH),
                8'(rxq.size()), 8'(txq.size())};
    endfunction

    function automatic bit m_irq();
        return (m_ctrl[2] && txq.size() <= 4) || (m_ctrl[3] && rxq.size() >= 8);
    endfunction

    // Register side effect as the bridge sees it, with the codec side idle.
    task automatic m_access(input bit r, input logic [10:0] a, input logic [3:0] be,
                            input logic [31:0] wd, output logic [31:0] exp);
        exp = 32'h0;
        case (a[3:2])
            2'd0: if (r) exp = {28'h0, m_ctrl}; else if (be[0]) m_ctrl = wd[3:0];
            2'd1: if (r) exp = m_status();
                  else if (be[2]) begin
                      if (wd[18]) m_ovf = 1'b0;
                      if (wd[19]) m_drop = 1'b0;
                  end
            2'd2: if (!r && be[1:0] == 2'b11) begin
                      if (txq.size() == DEPTH) m_drop = 1'b1;
                      else txq.push_back(wd[15:0]);
                  end
            default: if (r && rxq.size() > 0) exp = {16'h0, rxq.pop_front()};
        endcase
    endtask

    task automatic m_codec(input bit rdy, input bit inv, input logic [15:0] din);
        if (rdy && m_ctrl[0] && txq.size() > 0) void'(txq.pop_front());
        if (inv && m_ctrl[1]) begin
            if (rxq.size() == DEPTH) m_ovf = 1'b1;
            else rxq.push_back(din);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus_enable = 1'b0;
        sample_ready = 1'b0;
        sample_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        txq.delete();
        rxq.delete();
        m_ctrl = '0;
        m_ovf = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic bus_cycle(input bit r, input logic [10:0] a, input logic [3:0] be,
                             input logic [31:0] wd, output logic [31:0] rd);
        bit got = 1'b0;
        rd = '0;
        @(posedge clk);
        #1;
        address = a; rw = r; byte_enable = be; write_data = wd; bus_enable = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (acknowledge) begin
                got = 1'b1;
                rd = read_data;
            end
        end
        bus_enable = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL bus_ack_timeout addr=%h got no acknowledge within 8 cycles", a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic codec_cycle(input bit rdy, input bit inv, input logic [15:0] din,
                               output bit v, output logic [15:0] so);
        v = sample_valid;
        so = sample_out;
        sample_ready = rdy; sample_in_valid = inv; sample_in = din;
        @(posedge clk);
        #1;
        sample_ready = 1'b0;
        sample_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b1;
        #12;
        checks++;
        if ({acknowledge, irq, sample_valid, read_data} !== 35'h0) begin
            failures++;
            $display("FAIL reset_outputs got ack=%b irq=%b sv=%b rd=%h required all 0",
                     acknowledge, irq, sample_valid, read_data);
        end
        apply_reset();
        bus_cycle(1'b1, 11'h004, 4'hF, 32'h0, rd);
        checks++;
        if (rd !== 32'h0002_0000) begin
            failures++;
            $display("FAIL reset_status got=%h required=%h", rd, 32'h0002_0000);
        end
        bus_cycle(1'b1, 11'h000, 4'hF, 32'h0, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL reset_ctrl got=%h required=0", rd);
        end
    endtask

    task automatic test_ctrl_latency();
        logic [31:0] rd;
        logic [2:0]  ack_seq;
        int          extra_acks = 0;
        apply_reset();
        @(posedge clk);
        #1;
        address = 11'h000; rw = 1'b0; byte_enable = 4'b0001; write_data = 32'hFFFF_FFFF;
        bus_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 ack_seq[i] = acknowledge;
        end
        checks++;
        if (ack_seq !== 3'b010) begin
            failures++;
            $display("FAIL ack_latency got seq=%b required=010", ack_seq);
        end
        repeat (5) begin
            @(posedge clk);
            #1 if (acknowledge) extra_acks++;
        end
        checks++;
        if (extra_acks != 0) begin
            failures++;
            $display("FAIL held_request_reack got=%0d required=0", extra_acks);
        end
        bus_enable = 1'b0;
        @(posedge clk);
        #1;
        bus_cycle(1'b1, 11'h7F0, 4'hF, 32'h0, rd);
        checks++;
        if (rd !== 32'h0000_000F) begin
            failures++;
            $display("FAIL ctrl_readback got=%h required=%h", rd, 32'h0000_000F);
        end
    endtask

    task automatic test_tx_fill();
        logic [31:0] rd;
        bit          v;
        logic [15:0] so;
        int          bad = 0;
        apply_reset();
        bus_cycle(1'b0, 11'h000, 4'b0001, 32'h1, rd);
        for (int i = 0; i <= DEPTH; i++)
            bus_cycle(1'b0, 11'h008, 4'b0011, (i == DEPTH) ? 32'hABCD : i, rd);
        bus_cycle(1'b1, 11'h004, 4'hF, 32'h0, rd);
        checks++;
        if (rd !== 32'h000B_0010) begin
            failures++;
            $display("FAIL tx_full_status got=%h required=%h", rd, 32'h000B_0010);
        end
        for (int i = 0; i < DEPTH; i++) begin
            codec_cycle(1'b1, 1'b0, 16'h0, v, so);
            if (!v || so !== 16'(i)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL tx_drain_order got %0d bad samples required 0", bad);
        end
        checks++;
        if (sample_valid !== 1'b0) begin
            failures++;
            $display("FAIL tx_drained_valid got=%b required=0", sample_valid);
        end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] rd;
        bit          v;
        logic [15:0] so;
        logic [15:0] first;
        apply_reset();
        bus_cycle(1'b0, 11'h000, 4'b0001, 32'h2, rd);
        for (int i = 0; i <= DEPTH; i++) begin
            so = 16'($urandom);
            if (i == 0) first = so;
            codec_cycle(1'b0, 1'b1, so, v, so);
        end
        bus_cycle(1'b1, 11'h004, 4'hF, 32'h0, rd);
        checks++;
        if (rd !== 32'h0004_1000) begin
            failures++;
            $display("FAIL rx_overflow_status got=%h required=%h", rd, 32'h0004_1000);
        end
        bus_cycle(1'b1, 11'h00C, 4'hF, 32'h0, rd);
        checks++;
        if (rd !== {16'h0, first}) begin
            failures++;
            $display("FAIL rx_first_sample got=%h required=%h", rd, {16'h0, first});
        end
        bus_cycle(1'b1, 11'h004, 4'hF, 32'h0, rd);
        checks++;
        if (rd !== 32'h0004_0F00) begin
            failures++;
            $display("FAIL rx_level_after_pop got=%h required=%h", rd, 32'h0004_0F00);
        end
        bus_cycle(1'b0, 11'h004, 4'b0100, 32'h0004_0000, rd);
        bus_cycle(1'b1, 11'h004, 4'hF, 32'h0, rd);
        checks++;
        if (rd !== 32'h0000_0F00) begin
            failures++;
            $display("FAIL rx_overflow_w1c got=%h required=%h", rd, 32'h0000_0F00);
        end
    endtask

    task automatic test_rx_empty();
        logic [31:0] rd;
        apply_reset();
        bus_cycle(1'b0, 11'h000, 4'b0001, 32'h2, rd);
        bus_cycle(1'b1, 11'h00C, 4'hF, 32'h0, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL rx_empty_read got=%h required=0", rd);
        end
        bus_cycle(1'b1, 11'h004, 4'hF, 32'h0, rd);
        checks++;
        if (rd !== 32'h0002_0000) begin
            failures++;
            $display("FAIL rx_empty_status got=%h required=%h", rd, 32'h0002_0000);
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        bit          v;
        logic [15:0] so;
        apply_reset();
        bus_cycle(1'b0, 11'h000, 4'b0001, 32'hC, rd);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_tx_low got=%b required=1", irq);
        end
        for (int i = 0; i < 5; i++) bus_cycle(1'b0, 11'h008, 4'b0011, 32'($urandom), rd);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_tx_above_wm got=%b required=0", irq);
        end
        bus_cycle(1'b0, 11'h000, 4'b0001, 32'hE, rd);
        for (int i = 0; i < 8; i++) codec_cycle(1'b0, 1'b1, 16'($urandom), v, so);
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_rx_high got=%b required=1", irq);
        end
    endtask

    task automatic test_reset_mid_cycle();
        logic [31:0] rd;
        int          acks = 0;
        apply_reset();
        bus_cycle(1'b0, 11'h008, 4'b0011, 32'h1234, rd);
        bus_cycle(1'b0, 11'h008, 4'b0011, 32'h5678, rd);
        @(posedge clk);
        #1;
        address = 11'h000; rw = 1'b0; byte_enable = 4'b0001; write_data = 32'hF; bus_enable = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1 if (acknowledge) acks++;
        end
        reset = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1 if (acknowledge) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL reset_abort_ack got=%0d acks required=0", acks);
        end
        bus_enable = 1'b0;
        bus_cycle(1'b1, 11'h004, 4'hF, 32'h0, rd);
        checks++;
        if (rd !== 32'h0002_0000) begin
            failures++;
            $display("FAIL reset_mid_status got=%h required=%h", rd, 32'h0002_0000);
        end
        bus_cycle(1'b1, 11'h000, 4'hF, 32'h0, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_ctrl got=%h required=0", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp, wd;
        logic [10:0] a;
        logic [3:0]  be;
        logic [15:0] so, din;
        bit          r, v, rdy, inv;
        apply_reset();
        for (int n = 0; n < 150; n++) begin
            int kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                r = (kind >= 3);
                a = 11'($urandom);
                be = 4'($urandom);
                wd = $urandom;
                m_access(r, a, be, wd, exp);
                bus_cycle(r, a, be, wd, rd);
                if (r) begin
                    checks++;
                    if (rd !== exp) begin
                        failures++;
                        $display("FAIL rand_read op=%0d addr=%h got=%h required=%h", n, a, rd, exp);
                    end
                end
            end else begin
                rdy = 1'($urandom);
                inv = ($urandom_range(0, 3) != 0);
                din = 16'($urandom);
                codec_cycle(rdy, inv, din, v, so);
                checks++;
                if (v !== (m_ctrl[0] && txq.size() > 0) || (v && so !== txq[0])) begin
                    failures++;
                    $display("FAIL rand_sample op=%0d got v=%b d=%h required v=%b d=%h", n, v, so,
                             (m_ctrl[0] && txq.size() > 0), (txq.size() > 0) ? txq[0] : 16'h0);
                end
                m_codec(rdy, inv, din);
                @(posedge clk);
                #1;
            end
            checks++;
            if (irq !== m_irq()) begin
                failures++;
                $display("FAIL rand_irq op=%0d got=%b required=%b", n, irq, m_irq());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ctrl_latency();
        test_tx_fill();
        test_rx_overflow();
        test_rx_empty();
        test_irq();
        test_reset_mid_cycle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
